// File: rtl/countdown_timer_mmss.sv
// countdown_timer_mmss: loadable mm:ss down-counter decremented by a shared 1 Hz tick
// Optional feature macro: AUTO_RELOAD_EN (restart from the last loaded value at expiry)
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tick                1-cycle seconds strobe
//   load/load_min/sec   load (clamped) start time into count and reload registers
//   start/pause/clear   run control; priority clear > load > pause > start > tick
//   min_count/sec_count current time
//   running/done        state levels (RUN / DONE)
//   expire_pulse        1-cycle registered pulse after the edge that reaches 00:00
//   min_borrow          combinational: seconds about to borrow from minutes
module countdown_timer_mmss #(
   parameter int MAX_MIN = 59,
   parameter int SEC_MAX = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic [5:0] load_min,
   input  logic [5:0] load_sec,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [5:0] min_count,
   output logic [5:0] sec_count,
   output logic       running,
   output logic       done,
   output logic       expire_pulse,
   output logic       min_borrow
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);
   localparam logic [5:0] SEC_MAX_V = 6'(SEC_MAX);
   state_t state_q, state_d;
   logic [5:0] min_q, min_d, sec_q, sec_d;
   logic exp_q, exp_d;
   logic [5:0] ld_min, ld_sec;
   logic nonzero;
   assign ld_min = load_min > MAX_MIN_V ? MAX_MIN_V : load_min;
   assign ld_sec = load_sec > SEC_MAX_V ? SEC_MAX_V : load_sec;
   assign nonzero = (min_q != '0) || (sec_q != '0);
`ifdef AUTO_RELOAD_EN
   logic [5:0] rel_min_q, rel_min_d, rel_sec_q, rel_sec_d;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rel_min_q <= '0;
         rel_sec_q <= '0;
      end else begin
         rel_min_q <= rel_min_d;
         rel_sec_q <= rel_sec_d;
      end
   assign rel_min_d = load && !clear ? ld_min : rel_min_q;
   assign rel_sec_d = load && !clear ? ld_sec : rel_sec_q;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         min_q   <= '0;
         sec_q   <= '0;
         exp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         exp_q   <= exp_d;
      end
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      exp_d   = 1'b0;
      if (clear) begin
         state_d = IDLE;
         min_d   = '0;
         sec_d   = '0;
      end else if (load) begin
         min_d   = ld_min;
         sec_d   = ld_sec;
         state_d = state_q == DONE ? IDLE : state_q;
      end else if (pause) begin
         state_d = state_q == RUN ? PAUSE : state_q;
      end else if (start) begin
         // starting from 00:00 would expire without ever counting, so it is ignored
         state_d = (state_q == IDLE || state_q == PAUSE) && nonzero ? RUN : state_q;
      end else if (state_q == RUN && tick) begin
         if (sec_q != '0) sec_d = sec_q - 6'd1;
         else if (min_q != '0) begin
            sec_d = SEC_MAX_V;
            min_d = min_q - 6'd1;
         end
         // only 00:01 decrements into 00:00
         if (min_q == '0 && sec_q == 6'd1) begin
            exp_d   = 1'b1;
            state_d = DONE;
`ifdef AUTO_RELOAD_EN
            if (rel_min_q != '0 || rel_sec_q != '0) begin
               min_d   = rel_min_q;
               sec_d   = rel_sec_q;
               state_d = RUN;
            end
`endif
         end
      end
   end
   assign min_count    = min_q;
   assign sec_count    = sec_q;
   assign running      = state_q == RUN;
   assign done         = state_q == DONE;
   assign expire_pulse = exp_q;
   assign min_borrow   = state_q == RUN && tick && sec_q == '0 && min_q != '0;
endmodule

// File: tb/tb_countdown_timer_mmss.sv
// tb_countdown_timer_mmss: directed self-checking bench for countdown_timer_mmss
module tb_countdown_timer_mmss;
   logic clk = 1'b0, rst = 1'b1, tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
   logic [5:0] load_min = '0, load_sec = '0;
   logic [5:0] min_count, sec_count;
   logic running, done, expire_pulse, min_borrow;
   int total = 0, bad = 0;
   countdown_timer_mmss dut (
      .clk(clk), .rst(rst), .tick(tick), .load(load), .load_min(load_min), .load_sec(load_sec),
      .start(start), .pause(pause), .clear(clear), .min_count(min_count), .sec_count(sec_count),
      .running(running), .done(done), .expire_pulse(expire_pulse), .min_borrow(min_borrow)
   );
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
      tick = 0; load = 0; start = 0; pause = 0; clear = 0;
   endtask
   task automatic do_load(input logic [5:0] m, input logic [5:0] s);
      load = 1; load_min = m; load_sec = s;
      step();
   endtask
   task automatic do_tick;
      tick = 1;
      step();
   endtask
   task automatic do_start;
      start = 1;
      step();
   endtask
   task automatic test_reset;
      rst = 1;
      #2;
      total++;
      if ({min_count, sec_count, running, done, expire_pulse, min_borrow} !== 16'd0) begin
         bad++;
         $display("FAIL reset: got %0d:%0d run=%b done=%b exp=%b brw=%b want all zero",
                  min_count, sec_count, running, done, expire_pulse, min_borrow);
      end
      @(negedge clk);
      rst = 0;
      step();
   endtask
   task automatic test_borrow;
      logic [11:0] want [3] = '{12'(1 * 64 + 1), 12'(1 * 64 + 0), 12'(0 * 64 + 59)};
      do_load(6'd1, 6'd2);
      do_start();
      total++;
      if (running !== 1'b1) begin bad++; $display("FAIL borrow_run: got %b want 1", running); end
      for (int i = 0; i < 3; i++) begin
         tick = 1;
         #1;
         total++;
         if (min_borrow !== (i == 2)) begin
            bad++;
            $display("FAIL borrow_flag[%0d]: got %b want %b", i, min_borrow, i == 2);
         end
         step();
         total++;
         if ({min_count, sec_count} !== want[i]) begin
            bad++;
            $display("FAIL borrow_cnt[%0d]: got %0d:%0d want %0d:%0d", i, min_count, sec_count,
                     want[i][11:6], want[i][5:0]);
         end
      end
      clear = 1;
      step();
   endtask
   task automatic test_expire;
      int pulses = 0;
      do_load(6'd0, 6'd2);
      do_start();
      do_tick();
      total++;
      if ({min_count, sec_count, expire_pulse} !== {6'd0, 6'd1, 1'b0}) begin
         bad++;
         $display("FAIL exp_first: got %0d:%0d exp=%b want 0:1 exp=0", min_count, sec_count, expire_pulse);
      end
      do_tick();
      total++;
      if ({min_count, sec_count, done, running, expire_pulse} !== {12'd0, 1'b1, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL exp_reach: got %0d:%0d done=%b run=%b exp=%b want 0:0 1 0 1",
                  min_count, sec_count, done, running, expire_pulse);
      end
      for (int i = 0; i < 4; i++) begin
         do_tick();
         pulses += int'(expire_pulse);
      end
      total++;
      if ({min_count, sec_count, done, pulses[0]} !== {12'd0, 1'b1, 1'b0} || pulses != 0) begin
         bad++;
         $display("FAIL exp_hold: got %0d:%0d done=%b extra_pulses=%0d want 0:0 1 0",
                  min_count, sec_count, done, pulses);
      end
      do_start();
      total++;
      if ({done, running} !== 2'b10) begin
         bad++;
         $display("FAIL exp_start_ignored: got done=%b run=%b want 1 0", done, running);
      end
      do_load(6'd0, 6'd5);
      total++;
      if ({done, running, sec_count} !== {2'b00, 6'd5}) begin
         bad++;
         $display("FAIL exp_reload_idle: got done=%b run=%b sec=%0d want 0 0 5", done, running, sec_count);
      end
   endtask
   task automatic test_pause;
      do_load(6'd0, 6'd10);
      do_start();
      pause = 1; tick = 1;
      step();
      for (int i = 0; i < 5; i++) do_tick();
      total++;
      if ({min_count, sec_count, running} !== {6'd0, 6'd10, 1'b0}) begin
         bad++;
         $display("FAIL pause_hold: got %0d:%0d run=%b want 0:10 0", min_count, sec_count, running);
      end
      do_start();
      do_tick();
      total++;
      if ({min_count, sec_count, running} !== {6'd0, 6'd9, 1'b1}) begin
         bad++;
         $display("FAIL pause_resume: got %0d:%0d run=%b want 0:9 1", min_count, sec_count, running);
      end
      clear = 1;
      step();
   endtask
   task automatic test_clamp;
      do_load(6'd63, 6'd63);
      total++;
      if ({min_count, sec_count, running} !== {6'd59, 6'd59, 1'b0}) begin
         bad++;
         $display("FAIL clamp: got %0d:%0d run=%b want 59:59 0", min_count, sec_count, running);
      end
      load = 1; start = 1; load_min = 6'd2; load_sec = 6'd3;
      step();
      total++;
      if ({min_count, sec_count, running} !== {6'd2, 6'd3, 1'b0}) begin
         bad++;
         $display("FAIL load_start: got %0d:%0d run=%b want 2:3 0", min_count, sec_count, running);
      end
      do_load(6'd0, 6'd0);
      do_start();
      do_tick();
      total++;
      if ({min_count, sec_count, running, done} !== {12'd0, 2'b00}) begin
         bad++;
         $display("FAIL zero_start: got %0d:%0d run=%b done=%b want 0:0 0 0", min_count, sec_count, running, done);
      end
   endtask
   task automatic test_clear_rst;
      do_load(6'd0, 6'd30);
      do_start();
      do_tick();
      clear = 1; load = 1; load_min = 6'd5; load_sec = 6'd5;
      step();
      total++;
      if ({min_count, sec_count, running, done} !== {12'd0, 2'b00}) begin
         bad++;
         $display("FAIL clear_load: got %0d:%0d run=%b done=%b want 0:0 0 0", min_count, sec_count, running, done);
      end
      do_load(6'd0, 6'd1);
      do_start();
      tick = 1;
      @(negedge clk);
      rst = 1;
      #1;
      total++;
      if ({min_count, sec_count, running, done, expire_pulse, min_borrow} !== 16'd0) begin
         bad++;
         $display("FAIL rst_async: got %0d:%0d run=%b done=%b exp=%b want all zero",
                  min_count, sec_count, running, done, expire_pulse);
      end
      step();
      total++;
      if ({min_count, sec_count, done, expire_pulse} !== 14'd0) begin
         bad++;
         $display("FAIL rst_hold: got %0d:%0d done=%b exp=%b want 0:0 0 0", min_count, sec_count, done, expire_pulse);
      end
      @(negedge clk);
      rst = 0;
      step();
   endtask
`ifdef AUTO_RELOAD_EN
   task automatic test_autoreload;
      int pulses = 0;
      logic [5:0] want [4] = '{6'd1, 6'd2, 6'd1, 6'd2};
      do_load(6'd0, 6'd2);
      do_start();
      for (int i = 0; i < 4; i++) begin
         do_tick();
         pulses += int'(expire_pulse);
         total++;
         if ({min_count, sec_count, done, running} !== {6'd0, want[i], 2'b01}) begin
            bad++;
            $display("FAIL reload[%0d]: got %0d:%0d done=%b run=%b want 0:%0d 0 1",
                     i, min_count, sec_count, done, running, want[i]);
         end
      end
      total++;
      if (pulses != 2) begin bad++; $display("FAIL reload_pulses: got %0d want 2", pulses); end
      clear = 1;
      step();
   endtask
`endif
   initial begin
      test_reset();
      test_borrow();
`ifdef AUTO_RELOAD_EN
      test_autoreload();
`else
      test_expire();
`endif
      test_pause();
      test_clamp();
      test_clear_rst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
